// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the two-port asynchronous SRAM controller.
// Covers the chip geometry, the FSM state encoding and the requester indices.
package sram_ctrl_pkg;

  localparam int AW = 19;
  localparam int DW = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WS   = 3'd2,
    WP   = 3'd3,
    WH   = 3'd4
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way round-robin arbiter: on a tie the port that did not win last time is granted.
// last_grant only moves when the controller actually accepts a command (adv).
module sram_rr_arb
  import sram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt,
  output logic       last_grant
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt[PORT_A] = 1'b1;
      2'b10:   gnt[PORT_B] = 1'b1;
      2'b11: begin
        if (last_grant == PORT_B) gnt[PORT_A] = 1'b1;
        else                      gnt[PORT_B] = 1'b1;
      end
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= PORT_B;
    end else if (adv && (|gnt)) begin
      last_grant <= gnt[PORT_B];
    end
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Controller for a 512Kx16 asynchronous SRAM shared by two requesters.
// Chip strobes, address and data bus are registered from the next-state decode.
module sram_arb_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int RD_CYC = 2,
  parameter int WR_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [1:0]    a_be,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [1:0]    b_be,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] sram_a,
  inout  wire  [DW-1:0] sram_d,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic          sram_oen,
  output logic          sram_lbn,
  output logic          sram_ubn
);

  localparam int MAX_CYC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             capture;

  logic [1:0]       arb_req, arb_gnt;
  logic             last_grant;
  logic             adv, take, win_b;

  logic             port_q;
  logic [1:0]       be_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;

  logic             sel_we;
  logic             port_n;
  logic [1:0]       be_n;
  logic [AW-1:0]    addr_n;
  logic [DW-1:0]    wdata_n;
  logic             lbn_n, ubn_n, drv_n;

  logic             drive_q;
  logic [DW-1:0]    dout_q;

  assign arb_req = {b_req, a_req};
  assign adv     = (state == IDLE);

  sram_rr_arb u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (arb_req),
    .adv        (adv),
    .gnt        (arb_gnt),
    .last_grant (last_grant)
  );

  // Command fields of the winner, or the latched command once an access is underway.
  assign take    = adv && (|arb_gnt);
  assign win_b   = arb_gnt[PORT_B];
  assign sel_we  = win_b ? b_we : a_we;
  assign port_n  = take ? win_b : port_q;
  assign be_n    = take ? (win_b ? b_be    : a_be)    : be_q;
  assign addr_n  = take ? (win_b ? b_addr  : a_addr)  : addr_q;
  assign wdata_n = take ? (win_b ? b_wdata : a_wdata) : wdata_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          a_ack = arb_gnt[PORT_A];
          b_ack = arb_gnt[PORT_B];
          if (sel_we) begin
            state_nxt = WS;
          end else begin
            state_nxt = RD;
            cnt_nxt   = RD_LOAD;
          end
        end
      end
      RD: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WS: begin
        cnt_nxt   = WR_LOAD;
        state_nxt = WP;
      end
      WP: begin
        if (cnt == '0) state_nxt = WH;
        else           cnt_nxt   = cnt - 1'b1;
      end
      WH:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte lanes: reads always fetch the full word, writes follow the byte enables.
  always_comb begin
    lbn_n = 1'b1;
    ubn_n = 1'b1;
    drv_n = 1'b0;
    case (state_nxt)
      RD: begin
        lbn_n = 1'b0;
        ubn_n = 1'b0;
      end
      WS, WP, WH: begin
        lbn_n = ~be_n[0];
        ubn_n = ~be_n[1];
        drv_n = 1'b1;
      end
      default: begin
        lbn_n = 1'b1;
        ubn_n = 1'b1;
      end
    endcase
  end

  // Control and chip-facing registers; reset lands everything in a safe idle state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sram_cen <= 1'b1;
      sram_wen <= 1'b1;
      sram_oen <= 1'b1;
      sram_lbn <= 1'b1;
      sram_ubn <= 1'b1;
      sram_a   <= '0;
      drive_q  <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sram_cen <= (state_nxt == IDLE);
      sram_wen <= (state_nxt != WP);
      sram_oen <= (state_nxt != RD);
      sram_lbn <= lbn_n;
      sram_ubn <= ubn_n;
      drive_q  <= drv_n;
      if (state_nxt != IDLE) sram_a <= addr_n;
      a_rvalid <= capture && (port_q == PORT_A);
      b_rvalid <= capture && (port_q == PORT_B);
      if (capture && (port_q == PORT_A)) a_rdata <= sram_d;
      if (capture && (port_q == PORT_B)) b_rdata <= sram_d;
    end
  end

  // Datapath latches carry no reset; they are only consumed while the FSM is busy.
  always_ff @(posedge clk) begin
    if (take) begin
      port_q  <= win_b;
      be_q    <= be_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
    end
    dout_q <= wdata_n;
  end

  assign sram_d = drive_q ? dout_q : {DW{1'bz}};

endmodule
